ucode_sequencer: RTL and testbench

Microcode sequencer for the PIM controller. It fetches control words from the synchronous control memory, splits each word on its type bit into an array operation (EXEC) or a flow-control word (CTRL), and executes it. EXEC payloads go to the PIM datapath over a valid/ready handshake. CTRL words provide jump, counted loop and halt, so a whole microprogram runs from a single start pulse.

---
 rtl/ucode_sequencer.sv | 141 ++++++++++++++
 tb/tb_ucode_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: fetches control words from synchronous control memory, issues
// EXEC payloads to the datapath over valid/ready and executes JUMP/LOOP/SETCNT/HALT.
module ucode_sequencer #(
   parameter int AW = 6,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          cm_rd_en,
   output logic [AW-1:0] cm_addr,
   input  logic [CW-1:0] cm_rdata,
   output logic          op_valid,
   input  logic          op_ready,
   output logic [14:0]   op_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FETCH  = 2'b01,
      DECODE = 2'b10,
      ISSUE  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      OP_JUMP   = 2'b00,
      OP_LOOP   = 2'b01,
      OP_SETCNT = 2'b10,
      OP_HALT   = 2'b11
   } ctrl_op_t;

   localparam logic [AW-1:0] PC_ONE  = AW'(1);
   localparam logic [7:0]    CNT_ONE = 8'd1;

   state_t        state, state_nxt;
   logic [AW-1:0] pc, pc_nxt;
   logic [7:0]    cnt, cnt_nxt;
   logic [14:0]   op_data_nxt;
   logic          done_nxt;

   // Control-word fields, only meaningful while in DECODE.
   logic          is_ctrl;
   ctrl_op_t      ctrl_op;
   logic [AW-1:0] target;
   logic [7:0]    cnt_load;

   assign is_ctrl  = cm_rdata[CW-1];
   assign ctrl_op  = ctrl_op_t'(cm_rdata[14:13]);
   assign target   = cm_rdata[AW-1:0];
   assign cnt_load = cm_rdata[7:0];

   assign busy     = (state != IDLE);
   assign cm_rd_en = (state == FETCH);
   assign cm_addr  = pc;
   assign op_valid = (state == ISSUE);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= '0;
         cnt     <= '0;
         op_data <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         cnt     <= cnt_nxt;
         op_data <= op_data_nxt;
         done    <= done_nxt;
      end
   end

   // NOTE: every signal gets its hold value first, so no path through the case
   // statements leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      cnt_nxt     = cnt;
      op_data_nxt = op_data;
      done_nxt    = 1'b0;

      // Abort leaves pc, cnt and op_data untouched and suppresses done.
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pc_nxt    = start_addr;
                  state_nxt = FETCH;
               end
            end
            FETCH: begin
               state_nxt = DECODE;
            end
            DECODE: begin
               if (!is_ctrl) begin
                  op_data_nxt = cm_rdata[14:0];
                  state_nxt   = ISSUE;
               end else begin
                  state_nxt = FETCH;
                  case (ctrl_op)
                     OP_JUMP: begin
                        pc_nxt = target;
                     end
                     OP_LOOP: begin
                        if (cnt != 8'd0) begin
                           cnt_nxt = cnt - CNT_ONE;
                           pc_nxt  = target;
                        end else begin
                           pc_nxt = pc + PC_ONE;
                        end
                     end
                     OP_SETCNT: begin
                        cnt_nxt = cnt_load;
                        pc_nxt  = pc + PC_ONE;
                     end
                     OP_HALT: begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                     end
                  endcase
               end
            end
            ISSUE: begin
               if (op_ready) begin
                  pc_nxt    = pc + PC_ONE;
                  state_nxt = FETCH;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: table of microprograms with a payload
// scoreboard and fetch-address log, plus hand-written stall/abort/reset sequences.
module tb_ucode_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [5:0]  start_addr;
   logic        abort;
   logic        busy;
   logic        done;
   logic        cm_rd_en;
   logic [5:0]  cm_addr;
   logic [15:0] cm_rdata;
   logic        op_valid;
   logic        op_ready;
   logic [14:0] op_data;

   ucode_sequencer #(.AW(6), .CW(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .cm_rd_en   (cm_rd_en),
      .cm_addr    (cm_addr),
      .cm_rdata   (cm_rdata),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_data    (op_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [64];

   always @(posedge clk) begin
      if (cm_rd_en) cm_rdata <= mem[cm_addr];
   end

   typedef struct {
      logic [5:0]       addr;
      int               n_ops;
      logic [3:0][14:0] ops;
      int               n_fetch;
      logic [7:0][5:0]  fetches;
      int               done_cyc;
   } vec_t;

   vec_t        vecs [6];
   logic [14:0] exp_q [$];
   logic [5:0]  fetch_log [$];
   int          checks = 0;
   int          errors = 0;
   int          hs_cnt = 0;
   int          cur = 0;
   logic        hold = 1'b0;
   logic [14:0] hold_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: fetch log, payload scoreboard and op_data stability while stalled.
   always @(negedge clk) begin
      if (cm_rd_en) fetch_log.push_back(cm_addr);
      if (op_valid && hold) check("op_data_stable", {17'd0, op_data}, {17'd0, hold_data});
      if (op_valid && op_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) check("unexpected_handshake", 32'd1, 32'd0);
         else check("op_data_scoreboard", {17'd0, op_data}, {17'd0, exp_q.pop_front()});
         hold = 1'b0;
      end else begin
         hold      = op_valid;
         hold_data = op_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic do_start(input logic [5:0] a);
      start      = 1'b1;
      start_addr = a;
      cur        = 0;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int exp_cyc);
      while (!done && cur < 200) step();
      check("done_cycle", cur, exp_cyc);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      step();
      check("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   task automatic run_case(input int i);
      vec_t v;
      v = vecs[i];
      exp_q.delete();
      fetch_log.delete();
      hs_cnt   = 0;
      op_ready = 1'b1;
      for (int k = 0; k < v.n_ops; k++) exp_q.push_back(v.ops[k]);
      do_start(v.addr);
      wait_done(v.done_cyc);
      check("handshake_count", hs_cnt, v.n_ops);
      check("fetch_count", fetch_log.size(), v.n_fetch);
      for (int k = 0; k < v.n_fetch && k < fetch_log.size(); k++)
         check("fetch_addr", {26'd0, fetch_log[k]}, {26'd0, v.fetches[k]});
   endtask

   task automatic init_tables();
      for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
      mem[4]  = 16'h0123; mem[5]  = 16'h0456; mem[6]  = 16'hE000;
      mem[8]  = 16'hC002; mem[9]  = 16'h0011; mem[10] = 16'hA009; mem[11] = 16'hE000;
      mem[12] = 16'hC000; mem[13] = 16'h0022; mem[14] = 16'hA00D; mem[15] = 16'hE000;
      mem[16] = 16'hE000;
      mem[20] = 16'h8018; mem[24] = 16'h0055; mem[25] = 16'hE000;
      mem[63] = 16'h0007; mem[0]  = 16'h8020; mem[32] = 16'hE000;

      for (int i = 0; i < 6; i++) begin
         vecs[i].ops     = '0;
         vecs[i].fetches = '0;
      end
      // Straight line
      vecs[0].addr = 6'd4;  vecs[0].n_ops = 2; vecs[0].done_cyc = 9;
      vecs[0].ops[0] = 15'h123; vecs[0].ops[1] = 15'h456;
      vecs[0].n_fetch = 3;
      vecs[0].fetches[0] = 6'd4; vecs[0].fetches[1] = 6'd5; vecs[0].fetches[2] = 6'd6;
      // SETCNT 2 loop: body runs three times
      vecs[1].addr = 6'd8;  vecs[1].n_ops = 3; vecs[1].done_cyc = 20;
      for (int k = 0; k < 3; k++) vecs[1].ops[k] = 15'h011;
      vecs[1].n_fetch = 8;
      vecs[1].fetches[0] = 6'd8;  vecs[1].fetches[1] = 6'd9; vecs[1].fetches[2] = 6'd10;
      vecs[1].fetches[3] = 6'd9;  vecs[1].fetches[4] = 6'd10; vecs[1].fetches[5] = 6'd9;
      vecs[1].fetches[6] = 6'd10; vecs[1].fetches[7] = 6'd11;
      // SETCNT 0 loop: body runs once
      vecs[2].addr = 6'd12; vecs[2].n_ops = 1; vecs[2].done_cyc = 10;
      vecs[2].ops[0] = 15'h022;
      vecs[2].n_fetch = 4;
      vecs[2].fetches[0] = 6'd12; vecs[2].fetches[1] = 6'd13;
      vecs[2].fetches[2] = 6'd14; vecs[2].fetches[3] = 6'd15;
      // pc wrap 63 -> 0, then JUMP to 32
      vecs[3].addr = 6'd63; vecs[3].n_ops = 1; vecs[3].done_cyc = 8;
      vecs[3].ops[0] = 15'h007;
      vecs[3].n_fetch = 3;
      vecs[3].fetches[0] = 6'd63; vecs[3].fetches[1] = 6'd0; vecs[3].fetches[2] = 6'd32;
      // HALT only
      vecs[4].addr = 6'd16; vecs[4].n_ops = 0; vecs[4].done_cyc = 3;
      vecs[4].n_fetch = 1;
      vecs[4].fetches[0] = 6'd16;
      // JUMP first, then EXEC
      vecs[5].addr = 6'd20; vecs[5].n_ops = 1; vecs[5].done_cyc = 8;
      vecs[5].ops[0] = 15'h055;
      vecs[5].n_fetch = 3;
      vecs[5].fetches[0] = 6'd20; vecs[5].fetches[1] = 6'd24; vecs[5].fetches[2] = 6'd25;
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      abort      = 1'b0;
      op_ready   = 1'b0;
      init_tables();

      step();
      check("reset_outputs", {8'd0, busy, done, cm_rd_en, cm_addr, op_valid, op_data}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("idle_after_reset", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 6; i++) run_case(i);

      // Backpressure: 4 stalled cycles in the first ISSUE
      exp_q.delete(); fetch_log.delete();
      exp_q.push_back(15'h123); exp_q.push_back(15'h456);
      op_ready = 1'b0;
      do_start(6'd4);
      step(); step();
      check("first_op_cycle", cur, 3);
      for (int k = 0; k < 5; k++) begin
         check("stall_outputs", {15'd0, op_valid, cm_rd_en, op_data}, {15'd0, 1'b1, 1'b0, 15'h123});
         if (k == 4) op_ready = 1'b1;
         step();
      end
      check("fetch_after_stall", {24'd0, cm_rd_en, 1'b0, cm_addr}, {24'd0, 1'b1, 1'b0, 6'd5});
      wait_done(13);
      check("stall_scoreboard_empty", exp_q.size(), 0);

      // start pulsed in DECODE is ignored
      exp_q.delete();
      exp_q.push_back(15'h123); exp_q.push_back(15'h456);
      op_ready = 1'b1;
      do_start(6'd4);
      step();
      start = 1'b1; start_addr = 6'd16;
      step();
      start = 1'b0;
      check("busy_start_ignored", {16'd0, op_valid, op_data}, {16'd0, 1'b1, 15'h123});
      wait_done(9);
      check("busy_start_scoreboard_empty", exp_q.size(), 0);

      // abort in ISSUE with op_ready=0
      exp_q.delete();
      op_ready = 1'b0;
      do_start(6'd4);
      step(); step();
      check("abort_in_issue", {31'd0, op_valid}, 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("after_abort", {29'd0, busy, op_valid, done}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         check("no_done_after_abort", {30'd0, busy, done}, 32'd0);
      end

      // start and abort together in IDLE: abort wins
      start = 1'b1; abort = 1'b1; start_addr = 6'd4;
      step();
      start = 1'b0; abort = 1'b0;
      check("abort_beats_start", {31'd0, busy}, 32'd0);
      run_case(0);

      // asynchronous reset mid-ISSUE
      exp_q.delete();
      op_ready = 1'b0;
      do_start(6'd4);
      step(); step();
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs",
               {8'd0, busy, done, cm_rd_en, cm_addr, op_valid, op_data}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("idle_after_async_reset", {31'd0, busy}, 32'd0);
      run_case(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
